// File: rtl/path_dir_store_pkg.sv
// rtl/path_dir_store_pkg.sv - direction codes and decode helper shared by CU, datapath and direction store
package path_dir_store_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;

  localparam int DEFAULT_DEPTH = 256;

  // One-hot decode ordered {up, right, left, down}
  function automatic logic [3:0] decode_dir(input dir_e d);
    logic [3:0] oh;
    oh = 4'b0000;
    case (d)
      DIR_UP:    oh = 4'b1000;
      DIR_RIGHT: oh = 4'b0100;
      DIR_LEFT:  oh = 4'b0010;
      DIR_DOWN:  oh = 4'b0001;
      default:   oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/path_dir_store_dir_ram.sv
// rtl/path_dir_store_dir_ram.sv - DEPTH x 2 direction array, synchronous write, two asynchronous read ports
module path_dir_store_dir_ram
  import path_dir_store_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  dir_e          wdata,
  input  logic [AW-1:0] raddr_a,
  output dir_e          rdata_a,
  input  logic [AW-1:0] raddr_b,
  output dir_e          rdata_b
);

  dir_e mem [DEPTH];

  // Contents carry no reset; pointers in the parent define which slots are live
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Port a serves the stack top for backtracking, port b serves the replay pointer
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/path_dir_store.sv
// rtl/path_dir_store.sv - move-direction LIFO for maze search with FIFO-order path replay
module path_dir_store
  import path_dir_store_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [1:0]    din_dir,
  input  logic          pop,
  input  logic          qpop,
  output logic          up,
  output logic          right,
  output logic          left,
  output logic          down,
  output logic          err,
  output logic [1:0]    qdir,
  output logic          qvalid,
  output logic          full,
  output logic          ovf,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE       = (AW+1)'(1);

  logic [AW:0]   sp;
  logic [AW:0]   rp;
  logic [AW:0]   sp_dec;
  logic [AW-1:0] top_addr;
  logic          empty;
  logic          ram_we;
  dir_e          top_dir;
  dir_e          rep_dir;

  assign count    = sp;
  assign full     = (sp == DEPTH_CNT);
  assign empty    = (sp == '0);
  assign sp_dec   = sp - ONE;
  assign top_addr = sp_dec[AW-1:0];
  // Only an accepted push writes; clr and a full stack both suppress it
  assign ram_we   = push && !clr && !full;

  path_dir_store_dir_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dir_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (sp[AW-1:0]),
    .wdata   (dir_e'(din_dir)),
    .raddr_a (top_addr),
    .rdata_a (top_dir),
    .raddr_b (rp[AW-1:0]),
    .rdata_b (rep_dir)
  );

  // Pointer, decode and flag update with strobe priority clr > push > pop > qpop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp     <= '0;
      rp     <= '0;
      up     <= 1'b0;
      right  <= 1'b0;
      left   <= 1'b0;
      down   <= 1'b0;
      err    <= 1'b0;
      qdir   <= DIR_UP;
      qvalid <= 1'b0;
      ovf    <= 1'b0;
    end else if (clr) begin
      sp     <= '0;
      rp     <= '0;
      up     <= 1'b0;
      right  <= 1'b0;
      left   <= 1'b0;
      down   <= 1'b0;
      err    <= 1'b0;
      qdir   <= DIR_UP;
      qvalid <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      qvalid <= 1'b0;
      if (push) begin
        err <= 1'b0;
        if (full) begin
          ovf <= 1'b1;
        end else begin
          sp <= sp + ONE;
        end
      end else if (pop) begin
        if (empty) begin
          err <= 1'b1;
        end else begin
          {up, right, left, down} <= decode_dir(top_dir);
          sp  <= sp_dec;
          err <= 1'b0;
          // Keep replay from ever reading a slot the backtrack just freed
          if (rp > sp_dec) begin
            rp <= sp_dec;
          end
        end
      end else if (qpop) begin
        if (rp < sp) begin
          qdir   <= rep_dir;
          rp     <= rp + ONE;
          qvalid <= 1'b1;
          err    <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_path_dir_store.sv
// tb/tb_path_dir_store.sv - randomized self-checking bench for path_dir_store against a queue-based model
module tb_path_dir_store;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          push;
  logic [1:0]    din_dir;
  logic          pop;
  logic          qpop;
  logic          up, right, left, down;
  logic          err;
  logic [1:0]    qdir;
  logic          qvalid;
  logic          full;
  logic          ovf;
  logic [AW:0]   count;

  path_dir_store #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .push    (push),
    .din_dir (din_dir),
    .pop     (pop),
    .qpop    (qpop),
    .up      (up),
    .right   (right),
    .left    (left),
    .down    (down),
    .err     (err),
    .qdir    (qdir),
    .qvalid  (qvalid),
    .full    (full),
    .ovf     (ovf),
    .count   (count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the stored path as a queue, replay index as an int
  logic [1:0] m_stk [$];
  int         m_rp;
  logic [3:0] m_oh;
  logic       m_err;
  logic [1:0] m_qdir;
  logic       m_qvalid;
  logic       m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] dir_onehot(input logic [1:0] d);
    case (d)
      2'b00:   return 4'b1000;
      2'b01:   return 4'b0100;
      2'b10:   return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic model_reset();
    m_stk.delete();
    m_rp     = 0;
    m_oh     = 4'b0000;
    m_err    = 1'b0;
    m_qdir   = 2'b00;
    m_qvalid = 1'b0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic p, input logic [1:0] d,
                            input logic po, input logic qp);
    m_qvalid = 1'b0;
    if (c) begin
      model_reset();
    end else if (p) begin
      if (m_stk.size() == DEPTH) m_ovf = 1'b1;
      else m_stk.push_back(d);
      m_err = 1'b0;
    end else if (po) begin
      if (m_stk.size() == 0) begin
        m_err = 1'b1;
      end else begin
        m_oh  = dir_onehot(m_stk.pop_back());
        m_err = 1'b0;
        if (m_rp > m_stk.size()) m_rp = m_stk.size();
      end
    end else if (qp) begin
      if (m_rp < m_stk.size()) begin
        m_qdir   = m_stk[m_rp];
        m_rp     = m_rp + 1;
        m_qvalid = 1'b1;
        m_err    = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_count"},  32'(count), 32'(m_stk.size()));
    chk({tag, "_full"},   32'(full),  32'(m_stk.size() == DEPTH));
    chk({tag, "_ovf"},    32'(ovf),   32'(m_ovf));
    chk({tag, "_err"},    32'(err),   32'(m_err));
    chk({tag, "_qvalid"}, 32'(qvalid), 32'(m_qvalid));
    chk({tag, "_qdir"},   32'(qdir),  32'(m_qdir));
    chk({tag, "_onehot"}, 32'({up, right, left, down}), 32'(m_oh));
  endtask

  task automatic step(input string tag, input logic c, input logic p, input logic [1:0] d,
                      input logic po, input logic qp);
    clr = c; push = p; din_dir = d; pop = po; qpop = qp;
    @(posedge clk);
    model_step(c, p, d, po, qp);
    #1;
    clr = 1'b0; push = 1'b0; pop = 1'b0; qpop = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; push = 1'b0; din_dir = 2'b00; pop = 1'b0; qpop = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // 1: push up,right,down then pop x4
    step("t1_push", 0, 1, 2'b00, 0, 0);
    step("t1_push", 0, 1, 2'b01, 0, 0);
    step("t1_push", 0, 1, 2'b11, 0, 0);
    step("t1_pop1", 0, 0, 2'b00, 1, 0);
    chk("t1_pop1_down", 32'({up, right, left, down}), 32'h1);
    step("t1_pop2", 0, 0, 2'b00, 1, 0);
    chk("t1_pop2_right", 32'({up, right, left, down}), 32'h4);
    step("t1_pop3", 0, 0, 2'b00, 1, 0);
    chk("t1_pop3_up", 32'({up, right, left, down}), 32'h8);
    chk("t1_pop3_err", 32'(err), 32'h0);
    step("t1_pop4", 0, 0, 2'b00, 1, 0);
    chk("t1_pop4_err", 32'(err), 32'h1);
    chk("t1_pop4_count", 32'(count), 32'h0);

    // 2: push 01,01,10 then replay x4
    step("t2_clr", 1, 0, 2'b00, 0, 0);
    step("t2_push", 0, 1, 2'b01, 0, 0);
    step("t2_push", 0, 1, 2'b01, 0, 0);
    step("t2_push", 0, 1, 2'b10, 0, 0);
    step("t2_q1", 0, 0, 2'b00, 0, 1);
    step("t2_q2", 0, 0, 2'b00, 0, 1);
    step("t2_q3", 0, 0, 2'b00, 0, 1);
    chk("t2_q3_qdir", 32'(qdir), 32'h2);
    step("t2_q4", 0, 0, 2'b00, 0, 1);
    chk("t2_q4_err", 32'(err), 32'h1);
    chk("t2_q4_qvalid", 32'(qvalid), 32'h0);

    // 3: fill to DEPTH, overflow, clear
    step("t3_clr", 1, 0, 2'b00, 0, 0);
    for (int i = 0; i < DEPTH; i++) step("t3_fill", 0, 1, 2'($urandom), 0, 0);
    chk("t3_full", 32'(full), 32'h1);
    step("t3_ovf", 0, 1, 2'b11, 0, 0);
    chk("t3_ovf_flag", 32'(ovf), 32'h1);
    chk("t3_ovf_count", 32'(count), 32'(DEPTH));
    step("t3_clr2", 1, 0, 2'b00, 0, 0);
    chk("t3_clr_flags", 32'({full, ovf, err, qvalid}), 32'h0);

    // 4: push and pop together at count 2
    step("t4_push", 0, 1, 2'b10, 0, 0);
    step("t4_push", 0, 1, 2'b01, 0, 0);
    step("t4_both", 0, 1, 2'b11, 1, 0);
    chk("t4_count", 32'(count), 32'h3);

    // 5: push 3, qpop 1, pop 2, qpop exhausted
    step("t5_clr", 1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) step("t5_push", 0, 1, 2'(i + 1), 0, 0);
    step("t5_q", 0, 0, 2'b00, 0, 1);
    step("t5_pop", 0, 0, 2'b00, 1, 0);
    step("t5_pop", 0, 0, 2'b00, 1, 0);
    step("t5_q2", 0, 0, 2'b00, 0, 1);
    chk("t5_q2_err", 32'(err), 32'h1);

    // 6: async reset with count 5 and a decoded direction held
    step("t6_clr", 1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 6; i++) step("t6_push", 0, 1, 2'(i), 0, 0);
    step("t6_pop", 0, 0, 2'b00, 1, 0);
    #6 rst = 1'b1;
    #1;
    model_reset();
    check_all("t6_async");
    #1 rst = 1'b0;

    // Random mix of all strobes, including simultaneous ones
    for (int i = 0; i < 3000; i++) begin
      step("rand",
           ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 40),
           2'($urandom),
           ($urandom_range(0, 99) < 35),
           ($urandom_range(0, 99) < 40));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
